// File: rtl/round_key_add_unit_if.sv
// Bus bundle for round_key_add_unit: key-store write port, input block
// handshake and output result handshake.
//   slave  : the AddRoundKey unit itself
//   master : the driver (round datapath / key expansion / consumer side)
// Parameters:
//   BLK_W : state / round-key width in bits
//   IDX_W : width of round-index fields
interface round_key_add_unit_if #(
  parameter int unsigned BLK_W = 128,
  parameter int unsigned IDX_W = 4
) ();
  logic             key_wr_en;
  logic [IDX_W-1:0] key_wr_idx;
  logic [BLK_W-1:0] key_wr_data;
  logic             key_clear;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_round;
  logic [BLK_W-1:0] in_state;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_data;
  logic [IDX_W-1:0] out_round;
  logic             out_err;

  modport slave (
    input  key_wr_en, key_wr_idx, key_wr_data, key_clear,
    input  in_valid, in_round, in_state, out_ready,
    output in_ready, out_valid, out_data, out_round, out_err
  );

  modport master (
    output key_wr_en, key_wr_idx, key_wr_data, key_clear,
    output in_valid, in_round, in_state, out_ready,
    input  in_ready, out_valid, out_data, out_round, out_err
  );
endinterface

// File: rtl/round_key_add_unit.sv
// AddRoundKey engine for AES-128/192/256 datapaths.
// Holds NR+1 round keys with per-entry valid flags; each accepted state block
// is XORed with the key selected by its round index and queued in a 2-entry
// in-order output buffer.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   bus_io : key write port, input block handshake, output result handshake
//            (see round_key_add_unit_if)
module round_key_add_unit #(
  parameter int unsigned NK    = 4,
  parameter int unsigned BLK_W = 128,
  parameter int unsigned IDX_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  round_key_add_unit_if.slave bus_io
);

  localparam int unsigned     NR       = NK + 6;
  localparam int unsigned     IdxSpan  = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] NrIdx   = IDX_W'(NR);

  // Key store
  logic [BLK_W-1:0] key_q [NR+1];
  logic [NR:0]      kvalid_q, kvalid_d;
  logic             wr_ok;

  assign wr_ok = bus_io.key_wr_en && (bus_io.key_wr_idx <= NrIdx);

  // Contents need no reset; validity is tracked by kvalid_q.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      key_q[bus_io.key_wr_idx] <= bus_io.key_wr_data;
    end
  end

  // Clear first, then the write, so a same-cycle write survives the clear.
  always_comb begin
    kvalid_d = kvalid_q;
    if (bus_io.key_clear) begin
      kvalid_d = '0;
    end
    if (wr_ok) begin
      kvalid_d[bus_io.key_wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kvalid_q <= '0;
    end else begin
      kvalid_q <= kvalid_d;
    end
  end

  // Lookup uses registered key/flag, so a same-cycle write is not seen.
  logic [IdxSpan-1:0] kv_ext;
  logic               key_hit;
  logic [BLK_W-1:0]   res_data;

  assign kv_ext   = IdxSpan'(kvalid_q);
  assign key_hit  = (bus_io.in_round <= NrIdx) && kv_ext[bus_io.in_round];
  assign res_data = key_hit ? (bus_io.in_state ^ key_q[bus_io.in_round]) : bus_io.in_state;

  // Output buffer: head register drives the outputs directly so they hold
  // their last value when the buffer drains; tail is the second entry.
  logic [BLK_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [IDX_W-1:0] head_round_q, head_round_d, tail_round_q, tail_round_d;
  logic             head_err_q, head_err_d, tail_err_q, tail_err_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign bus_io.in_ready  = (cnt_q < 2'd2);
  assign bus_io.out_valid = (cnt_q != 2'd0);
  assign bus_io.out_data  = head_data_q;
  assign bus_io.out_round = head_round_q;
  assign bus_io.out_err   = head_err_q;

  assign push = bus_io.in_valid && bus_io.in_ready;
  assign pop  = bus_io.out_valid && bus_io.out_ready;

  always_comb begin
    head_data_d  = head_data_q;
    head_round_d = head_round_q;
    head_err_d   = head_err_q;
    tail_data_d  = tail_data_q;
    tail_round_d = tail_round_q;
    tail_err_d   = tail_err_q;
    cnt_d        = cnt_q;
    unique case (cnt_q)
      2'd0: begin
        if (push) begin
          head_data_d  = res_data;
          head_round_d = bus_io.in_round;
          head_err_d   = !key_hit;
          cnt_d        = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d  = res_data;
          head_round_d = bus_io.in_round;
          head_err_d   = !key_hit;
        end else if (push) begin
          tail_data_d  = res_data;
          tail_round_d = bus_io.in_round;
          tail_err_d   = !key_hit;
          cnt_d        = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        // No push possible here: in_ready is low when full.
        if (pop) begin
          head_data_d  = tail_data_q;
          head_round_d = tail_round_q;
          head_err_d   = tail_err_q;
          cnt_d        = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_q  <= '0;
      head_round_q <= '0;
      head_err_q   <= 1'b0;
      tail_data_q  <= '0;
      tail_round_q <= '0;
      tail_err_q   <= 1'b0;
      cnt_q        <= 2'd0;
    end else begin
      head_data_q  <= head_data_d;
      head_round_q <= head_round_d;
      head_err_q   <= head_err_d;
      tail_data_q  <= tail_data_d;
      tail_round_q <= tail_round_d;
      tail_err_q   <= tail_err_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_round_key_add_unit.sv
// Directed-vector bench for round_key_add_unit: one NK=4 instance for the
// functional and corner-case vectors, one NK=8 instance for the streaming run.
module tb_round_key_add_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  round_key_add_unit_if #(.BLK_W(128), .IDX_W(4)) b4 ();
  round_key_add_unit_if #(.BLK_W(128), .IDX_W(4)) b8 ();

  round_key_add_unit #(.NK(4), .BLK_W(128), .IDX_W(4)) u_dut4 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (b4)
  );

  round_key_add_unit #(.NK(8), .BLK_W(128), .IDX_W(4)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (b8)
  );

  localparam logic [127:0] K0   = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] S0   = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [127:0] R0   = 128'he9f74eec023020f61bf2ccf2353c21c7;
  localparam logic [127:0] S2   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SA   = 128'h11111111111111111111111111111111;
  localparam logic [127:0] SB   = 128'h22222222222222222222222222222222;
  localparam logic [127:0] SC   = 128'h33333333333333333333333333333333;
  localparam logic [127:0] K5   = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
  localparam logic [127:0] ONES = {128{1'b1}};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    b4.key_wr_en   = 1'b0;
    b4.key_wr_idx  = '0;
    b4.key_wr_data = '0;
    b4.key_clear   = 1'b0;
    b4.in_valid    = 1'b0;
    b4.in_round    = '0;
    b4.in_state    = '0;
  endtask

  task automatic wr4(input logic [3:0] idx, input logic [127:0] data);
    b4.key_wr_en   = 1'b1;
    b4.key_wr_idx  = idx;
    b4.key_wr_data = data;
    tick();
    b4.key_wr_en   = 1'b0;
  endtask

  // Present one block for one edge, then check the single result.
  task automatic blk4(input string tag, input logic [3:0] rnd, input logic [127:0] st,
                      input logic [127:0] exp_data, input logic exp_err);
    b4.in_valid = 1'b1;
    b4.in_round = rnd;
    b4.in_state = st;
    tick();
    b4.in_valid = 1'b0;
    check({tag, "_valid"}, 128'(b4.out_valid), 128'(1));
    check({tag, "_data"}, b4.out_data, exp_data);
    check({tag, "_err"}, 128'(b4.out_err), 128'(exp_err));
    check({tag, "_round"}, 128'(b4.out_round), 128'(rnd));
  endtask

  function automatic logic [127:0] key8(input int i);
    logic [7:0] b;
    b = 8'(i * 17 + 3);
    return {16{b}};
  endfunction

  function automatic logic [127:0] st8(input int i);
    logic [31:0] w;
    w = 32'ha5c30000 | 32'(i);
    return {w, ~w, w, ~w};
  endfunction

  initial begin
    idle4();
    b4.out_ready   = 1'b1;
    b8.key_wr_en   = 1'b0;
    b8.key_wr_idx  = '0;
    b8.key_wr_data = '0;
    b8.key_clear   = 1'b0;
    b8.in_valid    = 1'b0;
    b8.in_round    = '0;
    b8.in_state    = '0;
    b8.out_ready   = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 128'(b4.out_valid), 128'(0));
    check("rst_in_ready", 128'(b4.in_ready), 128'(1));
    check("rst_out_data", b4.out_data, 128'(0));
    check("rst_out_round", 128'(b4.out_round), 128'(0));
    check("rst_out_err", 128'(b4.out_err), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Missing key right after reset
    blk4("nokey_r3", 4'd3, S2, S2, 1'b1);
    tick();
    check("drain_valid", 128'(b4.out_valid), 128'(0));
    check("hold_data", b4.out_data, S2);

    // Key load and first XOR
    wr4(4'd0, K0);
    blk4("k0", 4'd0, S0, R0, 1'b0);

    // Illegal round index; write to idx 11 is ignored
    blk4("r11", 4'd11, S2, S2, 1'b1);
    wr4(4'd11, ONES);
    blk4("r11_after_wr", 4'd11, S2, S2, 1'b1);
    blk4("k0_again", 4'd0, S0, R0, 1'b0);
    tick();

    // Backpressure: A(r0), B(r3, no key), C(r0)
    b4.out_ready = 1'b0;
    b4.in_valid  = 1'b1;
    b4.in_round  = 4'd0;
    b4.in_state  = SA;
    tick();
    check("bp_rdy1", 128'(b4.in_ready), 128'(1));
    b4.in_round = 4'd3;
    b4.in_state = SB;
    tick();
    check("bp_rdy2", 128'(b4.in_ready), 128'(0));
    check("bp_head_a", b4.out_data, SA ^ K0);
    b4.in_round = 4'd0;
    b4.in_state = SC;
    tick();
    check("bp_rdy3", 128'(b4.in_ready), 128'(0));
    check("bp_valid3", 128'(b4.out_valid), 128'(1));
    check("bp_stable", b4.out_data, SA ^ K0);
    check("bp_stable_err", 128'(b4.out_err), 128'(0));
    b4.out_ready = 1'b1;
    tick();
    check("bp_head_b", b4.out_data, SB);
    check("bp_head_b_err", 128'(b4.out_err), 128'(1));
    check("bp_rdy_after_pop", 128'(b4.in_ready), 128'(1));
    tick();
    b4.in_valid = 1'b0;
    check("bp_head_c", b4.out_data, SC ^ K0);
    check("bp_valid_c", 128'(b4.out_valid), 128'(1));
    tick();
    check("bp_empty", 128'(b4.out_valid), 128'(0));

    // Same-cycle write and use of key 2
    wr4(4'd2, ONES);
    b4.key_wr_en   = 1'b1;
    b4.key_wr_idx  = 4'd2;
    b4.key_wr_data = '0;
    blk4("rbw_old", 4'd2, '0, ONES, 1'b0);
    b4.key_wr_en = 1'b0;
    blk4("rbw_new", 4'd2, '0, '0, 1'b0);

    // key_clear together with a write to idx 5
    b4.key_clear = 1'b1;
    wr4(4'd5, K5);
    b4.key_clear = 1'b0;
    blk4("clr_k5", 4'd5, S2, S2 ^ K5, 1'b0);
    blk4("clr_k0", 4'd0, S0, S0, 1'b1);
    tick();

    // Asynchronous reset with two results buffered
    b4.out_ready = 1'b0;
    b4.in_valid  = 1'b1;
    b4.in_round  = 4'd5;
    b4.in_state  = SA;
    tick();
    tick();
    b4.in_valid = 1'b0;
    check("pre_rst_full", 128'(b4.in_ready), 128'(0));
    #2 rst = 1'b1;
    #1;
    check("async_valid", 128'(b4.out_valid), 128'(0));
    check("async_ready", 128'(b4.in_ready), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    b4.out_ready = 1'b1;
    blk4("post_rst_k5", 4'd5, SA, SA, 1'b1);

    // NK=8 streaming: load keys 0..14, then 15 back-to-back blocks
    for (int i = 0; i < 15; i++) begin
      b8.key_wr_en   = 1'b1;
      b8.key_wr_idx  = 4'(i);
      b8.key_wr_data = key8(i);
      tick();
    end
    b8.key_wr_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      b8.in_valid = 1'b1;
      b8.in_round = 4'(i);
      b8.in_state = st8(i);
      check($sformatf("s8_rdy%0d", i), 128'(b8.in_ready), 128'(1));
      tick();
      check($sformatf("s8_valid%0d", i), 128'(b8.out_valid), 128'(1));
      check($sformatf("s8_data%0d", i), b8.out_data, st8(i) ^ key8(i));
      check($sformatf("s8_round%0d", i), 128'(b8.out_round), 128'(i));
      check($sformatf("s8_err%0d", i), 128'(b8.out_err), 128'(0));
    end
    b8.in_valid = 1'b0;
    tick();
    check("s8_empty", 128'(b8.out_valid), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/round_key_add_unit.md
Name: round_key_add_unit

Overview:
- Sequential, parametrised AddRoundKey engine for AES-128/192/256 datapaths.
- Holds all round keys in an internal key store of NR+1 entries, loaded through a write port.
- Accepts state blocks tagged with a round index over a valid/ready handshake, XORs each block with the selected round key, and returns the result through a 2-entry output buffer.
- Sits between the round-function datapath (SubBytes/ShiftRows/MixColumns) and the key-expansion block.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4/6/8. NR = NK+6 is derived locally (10/12/14).
- BLK_W, 128, state/round-key width in bits.
- IDX_W, 4, width of round-index fields; must hold NR.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- key_wr_en  in  1  write a round key this cycle.
- key_wr_idx  in  IDX_W  round index to write.
- key_wr_data  in  BLK_W  round-key value.
- key_clear  in  1  synchronous clear of all key-valid flags.
- in_valid  in  1  input block valid.
- in_ready  out  1  unit can accept a block.
- in_round  in  IDX_W  round index selecting the key.
- in_state  in  BLK_W  state block.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  BLK_W  state XOR key.
- out_round  out  IDX_W  echoed round index.
- out_err  out  1  result produced with a missing or illegal key.

Behaviour:
- Reset (asynchronous, active-high):
  - all key-valid flags = 0; buffer empty.
  - out_valid = 0, out_data = 0, out_round = 0, out_err = 0, in_ready = 1.
  - Key-store contents are don't-care.
  - Reset mid-transfer discards buffered results with no output.
- Key store writes:
  - Write when key_wr_en && key_wr_idx <= NR: store data, set that entry's valid flag.
  - key_wr_idx > NR: write ignored, no flag changes.
  - key_clear clears all valid flags.
  - key_clear and key_wr_en in the same cycle: clear applies first, then the write; the written entry ends valid.
- Input acceptance: transfer when in_valid && in_ready. in_ready = (buffer count < 2), a combinational function of registered count only.
- Result computation on an accepted block:
  - If in_round <= NR and the entry is valid: result = in_state ^ key[in_round], err = 0.
  - Otherwise: result = in_state unchanged, err = 1.
- Latency: result enters the buffer at the accepting edge; out_valid is asserted the following cycle (1-cycle latency when the buffer is empty).
- Read-before-write: a key write to the same index as an accepted block in the same cycle does not affect that block, which uses the old key/flag. The new key applies from the next cycle.
- Output buffer: 2-entry FIFO, in-order.
  - out_data/out_round/out_err reflect the head entry.
  - Head pops when out_valid && out_ready.
  - Simultaneous push and pop when full (count=2) is impossible because in_ready = 0.
  - Simultaneous push and pop at count=1 leaves count = 1.
  - Outputs hold stable while out_valid && !out_ready.
- When the buffer is empty: out_valid = 0, out_data/out_round/out_err hold their last values (0 after reset).
- Full throughput: one block per cycle is sustained while out_ready = 1.

Test Plan:
1. Key-store load: NK=4, write key_wr_idx=0, key 549932d1f08557681093ed9cbe2c974e; send in_round=0, in_state bd6e7c3df2b5779e0b61216e8b10b689, out_ready=1 -> next cycle out_valid=1, out_data e9f74eec023020f61bf2ccf2353c21c7, out_err=0, out_round=0.
2. Missing or illegal key:
   - After reset, send in_round=3 with no key loaded -> out_data = in_state, out_err=1.
   - Send in_round=11 with NK=4 -> out_err=1.
   - Write to idx 11 -> key store unchanged; a later round-11 block still flags err.
3. Backpressure: out_ready=0, present 3 back-to-back blocks -> first two accepted, in_ready=0 on the third cycle, outputs stable. Then raise out_ready -> results emerge in order, in_ready returns 1 after the first pop, and the third block completes.
4. Same-cycle key write and use: key[2]=all-ones loaded; in the same cycle write key[2]=0 and accept a round-2 block of 0 -> out_data = all-ones. The next round-2 block of 0 -> out_data = 0.
5. key_clear and reset:
   - key_clear with a simultaneous write to idx 5 -> idx 5 still usable (err=0), idx 0 now err=1.
   - Assert rst asynchronously with 2 results buffered -> out_valid=0 immediately, in_ready=1, all flags cleared.
6. Throughput: NK=8, load keys 0..14, stream 15 blocks with out_ready=1 -> 15 results on consecutive cycles, each out_data = state ^ key[round]; idx 14 accepted with err=0.
